vending_machine_core: RTL and testbench
=======================================

Name: vending_machine_core

Overview:
Parametrised successor to the fixed three-product vending FSM. It supports N products with per-product prices, coin credit accumulation and per-product stock counters with sold-out flags. It also provides unit-by-unit change return, cancel, and an inactivity-timeout refund. It sits between the button debouncers/coin acceptor and the board-level SSD/LED logic, running on the divided clock.

Parameters:
NUM_PRODUCTS, 3, number of selectable products
CREDIT_W, 8, width of credit, coin and price values
PRICES, {8'd15,8'd10,8'd5}, flat NUM_PRODUCTS*CREDIT_W vector; product i price at bits [i*CREDIT_W +: CREDIT_W]
MAX_CREDIT, 99, credit ceiling; a coin that would exceed it is rejected
CHANGE_UNIT, 5, value returned per change_pulse
STOCK_W, 4, stock counter width
STOCK_INIT, 9, stock of every product after reset/restock
VEND_CYCLES, 4, cycles product output is held
TIMEOUT_CYCLES, 1000, idle cycles with credit>0 before auto-refund

Ports:
clk  input  1  system clock (divided clock at board level)
reset  input  1  asynchronous, active-high reset
coin_valid  input  1  one-cycle strobe: coin present
coin_value  input  CREDIT_W  coin value, sampled when coin_valid=1
sel_btn  input  NUM_PRODUCTS  debounced select levels
cancel_btn  input  1  debounced cancel level
restock  input  1  level; refills all stock
product  output  NUM_PRODUCTS  one-hot vend drive
delivered  output  1  one-cycle pulse, end of vend
change_pulse  output  1  one pulse per CHANGE_UNIT returned
coin_reject  output  1  one-cycle pulse, coin refused
denied  output  1  one-cycle pulse, selection refused
credit  output  CREDIT_W  current credit (registered)
sold_out  output  NUM_PRODUCTS  bit i = stock[i]==0
busy  output  1  state != ACCEPT

Behaviour:
- Reset (async, any time, including mid-vend/mid-change): state ACCEPT, credit=0, all stock=STOCK_INIT, timer=0, all pulse outputs and product=0. Button-history registers are set to all-ones, so a button held through reset produces no edge.
- sel_btn and cancel_btn act on rising edges only, using a one-cycle history register. coin_valid is a strobe and is not edge-detected.
- ACCEPT:
  - Coin first: if coin_valid and credit+coin_value <= MAX_CREDIT, the coin is added, giving effective credit E. Otherwise coin_reject pulses and E = credit.
  - Event priority after the coin: cancel edge > select edge > restock.
  - Cancel edge with E>0 goes to CHANGE. Cancel with E=0 is ignored.
  - Select edge: the lowest index among simultaneous edges wins. If stock[i]==0 or E<price[i], denied pulses, credit=E, and the state stays ACCEPT. Otherwise credit=E-price[i], stock[i]-=1, product[i]=1, and the state goes to VEND.
  - restock=1 with no cancel/select edge sets all stock=STOCK_INIT.
  - Timer clears on any coin, edge, or credit==0. It otherwise increments. At TIMEOUT_CYCLES-1 with credit>0 the state goes to CHANGE.
- VEND:
  - product[i] is held exactly VEND_CYCLES cycles.
  - delivered=1 on the final VEND cycle.
  - Next state is ACCEPT with remaining credit kept for further purchases.
  - Buttons are ignored. coin_valid gives coin_reject.
- CHANGE, evaluated each cycle:
  - If credit >= CHANGE_UNIT: change_pulse=1 and credit -= CHANGE_UNIT.
  - Else credit=0 (remainder below unit is forfeited; coins/prices are specified as multiples of CHANGE_UNIT) and the state goes to ACCEPT.
  - Buttons are ignored. Coins are rejected.
- Stock never underflows: a select with stock 0 is always denied. Credit never exceeds MAX_CREDIT and never goes negative.
- sold_out and busy are combinational from registered state/stock. All other outputs are registered.
- Latency:
  - Coin to credit update: 1 cycle.
  - Select edge to product: 1 cycle.
  - Change pulses: 1 per cycle, back-to-back.

Decomposition:
- Package vending_pkg holds state encodings (ACCEPT, VEND, CHANGE) and a price-extract function.
- One sub-module, edge_detect (parametrised WIDTH), is used for sel_btn and cancel_btn.
- Timer width is $clog2(TIMEOUT_CYCLES). Vend counter width is $clog2(VEND_CYCLES+1).

Test Plan:
- Coins 10, 10 then sel_btn[2] edge: credit 20→product[2] for 4 cycles, delivered on 4th, credit=5, stock[2]=8.
- Credit 5, sel_btn[1] edge: denied pulse, credit stays 5. Then cancel: one change_pulse, credit 0, back to ACCEPT.
- Credit 95, coin 10: coin_reject, credit 95. A coin of 5 then gives 100>99 and is also rejected. A coin of 0 is accepted.
- Buy product 0 nine times with ample credit: sold_out[0]=1, tenth select is denied. restock in ACCEPT clears sold_out[0] and stock=9.
- TIMEOUT_CYCLES=20, credit 15, no activity: after 20 cycles CHANGE gives 3 change_pulses, credit 0.
- Assert reset during VEND cycle 2 and during CHANGE: all outputs 0 immediately, credit 0, stock=9, held sel_btn produces no vend after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending machine core: FSM state encoding
// and extraction of one price from the flat per-product price vector.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam int PRICE_MAX_W     = 32;
    localparam int PRICE_VEC_MAX_W = 1024;

    function automatic logic [PRICE_MAX_W-1:0] price_at(
        input logic [PRICE_VEC_MAX_W-1:0] prices,
        input int                         idx,
        input int                         width
    );
        logic [PRICE_VEC_MAX_W-1:0] v_shifted;
        logic [PRICE_MAX_W-1:0]     v_mask;
        v_shifted = prices >> (idx * width);
        if (width >= PRICE_MAX_W) begin
            v_mask = '1;
        end else begin
            v_mask = (32'd1 << width) - 32'd1;
        end
        return v_shifted[PRICE_MAX_W-1:0] & v_mask;
    endfunction

endpackage

// File: rtl/vending_machine_core_edge_detect.sv
// Rising-edge detector for debounced button levels. History resets to all-ones
// so a button already held when reset is released never produces an edge.
module edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_hist;

    // one-cycle history of the button levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '1;
        end else begin
            r_hist <= i_level;
        end
    end

    assign o_rise = i_level & ~r_hist;

endmodule

// File: rtl/vending_machine_core.sv
// N-product vending controller: coin credit, per-product stock, timed vend,
// unit-by-unit change return on cancel or inactivity timeout.
module vending_machine_core
    import vending_pkg::*;
#(
    parameter int                                NUM_PRODUCTS   = 3,
    parameter int                                CREDIT_W       = 8,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]  PRICES         = {8'd15, 8'd10, 8'd5},
    parameter int                                MAX_CREDIT     = 99,
    parameter int                                CHANGE_UNIT    = 5,
    parameter int                                STOCK_W        = 4,
    parameter int                                STOCK_INIT     = 9,
    parameter int                                VEND_CYCLES    = 4,
    parameter int                                TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    coin_valid,
    input  logic [CREDIT_W-1:0]     coin_value,
    input  logic [NUM_PRODUCTS-1:0] sel_btn,
    input  logic                    cancel_btn,
    input  logic                    restock,
    output logic [NUM_PRODUCTS-1:0] product,
    output logic                    delivered,
    output logic                    change_pulse,
    output logic                    coin_reject,
    output logic                    denied,
    output logic [CREDIT_W-1:0]     credit,
    output logic [NUM_PRODUCTS-1:0] sold_out,
    output logic                    busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int VC_W  = $clog2(VEND_CYCLES + 1);
    localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
    localparam int SUM_W = CREDIT_W + 1;

    state_t                  r_state;
    logic [CREDIT_W-1:0]     r_credit;
    logic [STOCK_W-1:0]      r_stock [NUM_PRODUCTS];
    logic [TMR_W-1:0]        r_timer;
    logic [VC_W-1:0]         r_vcnt;
    logic [NUM_PRODUCTS-1:0] r_product;
    logic                    r_delivered;
    logic                    r_change;
    logic                    r_reject;
    logic                    r_denied;

    logic [NUM_PRODUCTS-1:0] w_sel_rise;
    logic [0:0]              w_cancel_rise;
    logic [CREDIT_W-1:0]     w_price [NUM_PRODUCTS];
    logic [SUM_W-1:0]        w_sum;
    logic                    w_coin_ok;
    logic [CREDIT_W-1:0]     w_eff;
    logic [SEL_W-1:0]        w_sel_idx;
    logic                    w_sel_any;
    logic                    w_sel_ok;
    logic                    w_cancel_go;
    logic                    w_timeout;

    edge_detect #(.WIDTH(NUM_PRODUCTS)) u_sel_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (sel_btn),
        .o_rise  (w_sel_rise)
    );

    edge_detect #(.WIDTH(1)) u_cancel_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (cancel_btn),
        .o_rise  (w_cancel_rise)
    );

    // effective credit after the coin, winning select and its eligibility
    always_comb begin
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            w_price[i] = CREDIT_W'(price_at(PRICE_VEC_MAX_W'(PRICES), i, CREDIT_W));
        end
        w_sum     = {1'b0, r_credit} + {1'b0, coin_value};
        w_coin_ok = coin_valid && (w_sum <= SUM_W'(MAX_CREDIT));
        w_eff     = w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;
        w_sel_idx = '0;
        for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
            if (w_sel_rise[i]) begin
                w_sel_idx = SEL_W'(i);
            end else begin
                w_sel_idx = w_sel_idx;
            end
        end
        w_sel_any   = |w_sel_rise;
        w_sel_ok    = (r_stock[w_sel_idx] != '0) && (w_eff >= w_price[w_sel_idx]);
        w_cancel_go = w_cancel_rise[0] && (w_eff != '0);
        w_timeout   = !coin_valid && !w_cancel_rise[0] && !w_sel_any &&
                      (r_credit != '0) && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    end

    // main controller FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ACCEPT;
            r_credit    <= '0;
            r_timer     <= '0;
            r_vcnt      <= '0;
            r_product   <= '0;
            r_delivered <= 1'b0;
            r_change    <= 1'b0;
            r_reject    <= 1'b0;
            r_denied    <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            r_delivered <= 1'b0;
            r_change    <= 1'b0;
            r_denied    <= 1'b0;
            r_reject    <= coin_valid;
            case (r_state)
                ST_ACCEPT: begin
                    r_reject <= coin_valid && !w_coin_ok;
                    if (coin_valid || w_cancel_rise[0] || w_sel_any || r_credit == '0 || w_timeout) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                    if (w_cancel_go) begin
                        r_credit <= w_eff;
                        r_state  <= ST_CHANGE;
                    end else if (w_sel_any && w_sel_ok) begin
                        r_credit             <= w_eff - w_price[w_sel_idx];
                        r_stock[w_sel_idx]   <= r_stock[w_sel_idx] - STOCK_W'(1);
                        r_product            <= NUM_PRODUCTS'(1) << w_sel_idx;
                        r_vcnt               <= VC_W'(1);
                        r_delivered          <= (VEND_CYCLES == 1);
                        r_state              <= ST_VEND;
                    end else if (w_sel_any) begin
                        r_credit <= w_eff;
                        r_denied <= 1'b1;
                    end else begin
                        r_credit <= w_eff;
                        if (restock) begin
                            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                                r_stock[i] <= STOCK_W'(STOCK_INIT);
                            end
                        end
                        if (w_timeout) begin
                            r_state <= ST_CHANGE;
                        end
                    end
                end
                ST_VEND: begin
                    r_timer <= '0;
                    if (r_vcnt == VC_W'(VEND_CYCLES)) begin
                        r_product <= '0;
                        r_vcnt    <= '0;
                        r_state   <= ST_ACCEPT;
                    end else begin
                        r_vcnt      <= r_vcnt + VC_W'(1);
                        r_delivered <= (r_vcnt == VC_W'(VEND_CYCLES - 1));
                    end
                end
                ST_CHANGE: begin
                    r_timer <= '0;
                    // a remainder below one unit is forfeited
                    if (r_credit >= CREDIT_W'(CHANGE_UNIT)) begin
                        r_change <= 1'b1;
                        r_credit <= r_credit - CREDIT_W'(CHANGE_UNIT);
                    end else begin
                        r_credit <= '0;
                        r_state  <= ST_ACCEPT;
                    end
                end
                default: begin
                    r_state <= ST_ACCEPT;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            sold_out[i] = (r_stock[i] == '0);
        end
    end

    assign product      = r_product;
    assign delivered    = r_delivered;
    assign change_pulse = r_change;
    assign coin_reject  = r_reject;
    assign denied       = r_denied;
    assign credit       = r_credit;
    assign busy         = (r_state != ST_ACCEPT);

endmodule

// File: tb/tb_vending_machine_core.sv
// Directed bench for vending_machine_core: a vector table for the purchase,
// coin-limit and sold-out flows, plus sequences for timeouts and mid-flow reset.
module tb_vending_machine_core;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic [2:0] sel_btn;
    logic       cancel_btn;
    logic       restock;
    logic [2:0] product;
    logic       delivered;
    logic       change_pulse;
    logic       coin_reject;
    logic       denied;
    logic [7:0] credit;
    logic [2:0] sold_out;
    logic       busy;

    int n_vec;
    int n_miss;

    typedef struct {
        logic       cv;
        logic [7:0] cval;
        logic [2:0] sel;
        logic       cancel;
        logic       rst_k;
        logic [2:0] e_prod;
        logic       e_del;
        logic       e_chg;
        logic       e_rej;
        logic       e_den;
        logic [7:0] e_cred;
        logic [2:0] e_so;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    vending_machine_core #(.TIMEOUT_CYCLES(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_btn      (sel_btn),
        .cancel_btn   (cancel_btn),
        .restock      (restock),
        .product      (product),
        .delivered    (delivered),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .denied       (denied),
        .credit       (credit),
        .sold_out     (sold_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic cv, input logic [7:0] cval, input logic [2:0] sel,
                                input logic cancel, input logic rk, input logic [2:0] e_prod,
                                input logic e_del, input logic e_chg, input logic e_rej,
                                input logic e_den, input logic [7:0] e_cred, input logic [2:0] e_so,
                                input logic e_busy);
        vec_t v;
        v.cv = cv; v.cval = cval; v.sel = sel; v.cancel = cancel; v.rst_k = rk;
        v.e_prod = e_prod; v.e_del = e_del; v.e_chg = e_chg; v.e_rej = e_rej;
        v.e_den = e_den; v.e_cred = e_cred; v.e_so = e_so; v.e_busy = e_busy;
        return v;
    endfunction

    function automatic logic [18:0] outs();
        return {product, delivered, change_pulse, coin_reject, denied, credit, sold_out, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drain(output int pulses, output int stuck);
        pulses = 0;
        stuck  = 1;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (change_pulse) pulses++;
            if (!busy) begin
                stuck = 0;
                break;
            end
        end
    endtask

    initial begin
        int   pulses;
        int   stuck;
        vec_t v;
        logic [18:0] exp_w;
        n_vec = 0; n_miss = 0;
        reset = 1'b1; coin_valid = 1'b0; coin_value = 8'd0;
        sel_btn = 3'b000; cancel_btn = 1'b0; restock = 1'b0;

        // vector table: inputs, then expected outputs one edge later
        vecs.push_back(mk(1'b1, 8'd10, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10, 3'b000, 1'b0));
        vecs.push_back(mk(1'b1, 8'd10, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,  3'b100, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  3'b000, 1'b1));
        vecs.push_back(mk(1'b1, 8'd5,  3'b100, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5,  3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0,  3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0,  3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5,  3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0,  3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,  3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5,  3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,  3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,  3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,  3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0,  3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0,  3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  3'b000, 1'b0));
        // credit ceiling
        vecs.push_back(mk(1'b1, 8'd50, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd50, 3'b000, 1'b0));
        vecs.push_back(mk(1'b1, 8'd45, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd95, 3'b000, 1'b0));
        vecs.push_back(mk(1'b1, 8'd10, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd95, 3'b000, 1'b0));
        vecs.push_back(mk(1'b1, 8'd5,  3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd95, 3'b000, 1'b0));
        vecs.push_back(mk(1'b1, 8'd0,  3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd95, 3'b000, 1'b0));
        // nine purchases of product 0 (price 5) exhaust its stock
        for (int k = 1; k <= 9; k++) begin
            logic [7:0] c;
            logic [2:0] so;
            c  = 8'(95 - 5 * k);
            so = (k == 9) ? 3'b001 : 3'b000;
            vecs.push_back(mk(1'b0, 8'd0, 3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, c, so, 1'b1));
            vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, c, so, 1'b1));
            vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, c, so, 1'b1));
            vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, c, so, 1'b1));
            vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, c, so, 1'b0));
        end
        vecs.push_back(mk(1'b0, 8'd0, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd50, 3'b001, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd50, 3'b001, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd50, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd50, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0, 3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd45, 3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd45, 3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd45, 3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd45, 3'b000, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd45, 3'b000, 1'b0));

        repeat (2) tick();
        chk("reset_state", 32'(outs()), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            coin_valid = v.cv; coin_value = v.cval; sel_btn = v.sel;
            cancel_btn = v.cancel; restock = v.rst_k;
            tick();
            exp_w = {v.e_prod, v.e_del, v.e_chg, v.e_rej, v.e_den, v.e_cred, v.e_so, v.e_busy};
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(exp_w));
        end
        coin_valid = 1'b0; coin_value = 8'd0; sel_btn = 3'b000; cancel_btn = 1'b0; restock = 1'b0;

        // cancel with 45 credit returns nine units
        cancel_btn = 1'b1;
        tick();
        chk("cancel_busy", 32'(busy), 32'd1);
        cancel_btn = 1'b0;
        drain(pulses, stuck);
        chk("cancel_done", 32'(stuck), 32'd0);
        chk("cancel_pulses", 32'(pulses), 32'd9);
        chk("cancel_credit", 32'(credit), 32'd0);

        // inactivity timeout refunds 15 as three units
        coin_valid = 1'b1; coin_value = 8'd15;
        tick();
        coin_valid = 1'b0; coin_value = 8'd0;
        chk("to_credit", 32'(credit), 32'd15);
        repeat (19) tick();
        chk("to_not_yet", 32'(busy), 32'd0);
        tick();
        chk("to_fired", 32'(busy), 32'd1);
        drain(pulses, stuck);
        chk("to_done", 32'(stuck), 32'd0);
        chk("to_pulses", 32'(pulses), 32'd3);
        chk("to_credit0", 32'(credit), 32'd0);

        // reset during the second vend cycle, select held through release
        coin_valid = 1'b1; coin_value = 8'd10;
        tick();
        coin_valid = 1'b0; coin_value = 8'd0; sel_btn = 3'b001;
        tick();
        tick();
        chk("vend2_product", 32'(product), 32'd1);
        #2 reset = 1'b1;
        #1 chk("rst_vend_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_vend_held", 32'({product, denied, busy}), 32'd0);
        end
        sel_btn = 3'b000;

        // reset during change return, cancel held through release
        coin_valid = 1'b1; coin_value = 8'd20;
        tick();
        coin_valid = 1'b0; coin_value = 8'd0; cancel_btn = 1'b1;
        tick();
        tick();
        chk("chg_pulse", 32'({change_pulse, credit}), 32'({1'b1, 8'd15}));
        #2 reset = 1'b1;
        #1 chk("rst_chg_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_chg_held", 32'({change_pulse, busy}), 32'd0);
        end
        cancel_btn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
